// File: rtl/pipeline_stage.sv
// pipeline_stage: one elastic valid/ready register slice.
module pipeline_stage #(
  parameter int WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready
);
  logic [WIDTH-1:0] data_d, data_q;
  logic             valid_d, valid_q;
  always_comb begin
    in_ready = !valid_q || out_ready;
    valid_d  = in_ready ? in_valid : valid_q;
    data_d   = (in_ready && in_valid) ? in_data : data_q;
  end
  always_ff @(posedge clk_i) begin
    valid_q <= rst_i ? 1'b0 : valid_d;
    data_q  <= data_d;
  end
  assign out_data  = data_q;
  assign out_valid = valid_q;
endmodule

// File: rtl/pipeline_stages.sv
// pipeline_stages: NUM_STAGES chained elastic slices; zero stages is a wire.
module pipeline_stages #(
  parameter int WIDTH      = 8,
  parameter int NUM_STAGES = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [WIDTH-1:0] data_in,
  input  logic             data_in_valid,
  output logic             data_in_ready,
  output logic [WIDTH-1:0] data_out,
  output logic             data_out_valid,
  input  logic             data_out_ready
);
  if (NUM_STAGES == 0) begin : g_pass
    assign data_out       = data_in;
    assign data_out_valid = data_in_valid;
    assign data_in_ready  = data_out_ready;
  end else begin : g_pipe
    // Per-stage nets keep the combinational ready chain free of vector self-loops.
    for (genvar k = 0; k < NUM_STAGES; k++) begin : g_st
      logic [WIDTH-1:0] id, od;
      logic             iv, ov, ir, orr;
      if (k == 0) begin : g_in
        assign id = data_in;
        assign iv = data_in_valid;
      end else begin : g_mid
        assign id = g_st[k-1].od;
        assign iv = g_st[k-1].ov;
      end
      if (k == NUM_STAGES - 1) begin : g_out
        assign orr = data_out_ready;
      end else begin : g_nxt
        assign orr = g_st[k+1].ir;
      end
      pipeline_stage #(.WIDTH(WIDTH)) u_stage (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .in_data  (id),
        .in_valid (iv),
        .in_ready (ir),
        .out_data (od),
        .out_valid(ov),
        .out_ready(orr)
      );
    end
    assign data_in_ready  = g_st[0].ir;
    assign data_out       = g_st[NUM_STAGES-1].od;
    assign data_out_valid = g_st[NUM_STAGES-1].ov;
  end
endmodule

// File: tb/tb_pipeline_stages.sv
// tb_pipeline_stages: random and directed checks against a beat-position model.
module tb_pipeline_stages;
  localparam int W = 8;
  localparam int N = 8;
  logic         clk_i = 1'b0;
  logic         rst_i = 1'b0;
  logic [W-1:0] data_in = '0;
  logic         data_in_valid = 1'b0;
  logic         data_in_ready;
  logic [W-1:0] data_out;
  logic         data_out_valid;
  logic         data_out_ready = 1'b0;

  pipeline_stages #(.WIDTH(W), .NUM_STAGES(N)) dut (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .data_in       (data_in),
    .data_in_valid (data_in_valid),
    .data_in_ready (data_in_ready),
    .data_out      (data_out),
    .data_out_valid(data_out_valid),
    .data_out_ready(data_out_ready)
  );

  always #5 clk_i = ~clk_i;

  // Model: in-flight beats in order, each with its slot index (0 = entry, N-1 = head).
  typedef struct {logic [W-1:0] d; int p;} beat_t;
  beat_t q[$];
  int n_chk = 0;
  int n_fail = 0;
  logic         exp_ready, exp_ov;
  logic [W-1:0] exp_data;
  logic [W+1:0] obs, exp_b;

  task automatic drive(input bit r, input bit v, input logic [W-1:0] d, input bit o);
    rst_i = r;
    data_in_valid = v;
    data_in = d;
    data_out_ready = o;
    #1;
    exp_ready = (q.size() < N) || o;
    exp_ov    = q.size() > 0 && q[0].p == N - 1;
    exp_data  = exp_ov ? q[0].d : '0;
    exp_b     = {exp_ready, exp_ov, exp_data};
    obs       = {data_in_ready, data_out_valid, data_out_valid ? data_out : {W{1'b0}}};
  endtask

  task automatic advance();
    @(posedge clk_i);
    if (rst_i) q.delete();
    else begin
      bit push;
      push = data_in_valid && exp_ready;
      if (exp_ov && data_out_ready) void'(q.pop_front());
      for (int i = 0; i < q.size(); i++) begin
        int lim;
        lim = (i == 0) ? N : q[i-1].p;
        if (q[i].p + 1 < lim) q[i].p++;
      end
      if (push) q.push_back('{d: data_in, p: 0});
    end
    @(negedge clk_i);
  endtask

  task automatic test_reset();
    drive(1, 1, 8'hAA, 1);
    advance();
    drive(1, 1, 8'hAA, 1);
    n_chk++;
    if (data_out_valid !== 1'b0 || data_in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_hold: valid=%b ready=%b, required valid=0 ready=1", data_out_valid, data_in_ready);
    end
    advance();
    for (int c = 0; c < 12; c++) begin
      drive(0, 0, 8'h00, 1);
      n_chk++;
      if (obs !== exp_b || data_out_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_idle c%0d: got %h required %h", c, obs, exp_b);
      end
      advance();
    end
  endtask

  task automatic test_latency();
    int got = 0;
    int first = -1;
    for (int c = 0; c < 100 && got < 16; c++) begin
      drive(0, c < 16, W'(c), 1);
      n_chk++;
      if (obs !== exp_b) begin
        n_fail++;
        $display("FAIL latency_cycle c%0d: got %h required %h", c, obs, exp_b);
      end
      if (data_out_valid) begin
        if (first < 0) first = c;
        n_chk++;
        if (data_out !== W'(got) || c != 8 + got) begin
          n_fail++;
          $display("FAIL latency_stream beat%0d: got %h at c%0d required %h at c%0d", got, data_out, c, got, 8 + got);
        end
        got++;
      end
      advance();
    end
    n_chk++;
    if (first != 8 || got != 16) begin
      n_fail++;
      $display("FAIL latency_first: first=%0d beats=%0d required first=8 beats=16", first, got);
    end
  endtask

  task automatic test_full();
    int acc = 0;
    for (int c = 0; c < 12; c++) begin
      drive(0, 1, W'(8'h10 + acc), 0);
      n_chk++;
      if (obs !== exp_b) begin
        n_fail++;
        $display("FAIL full_cycle c%0d: got %h required %h", c, obs, exp_b);
      end
      if (data_in_ready) acc++;
      advance();
    end
    n_chk++;
    if (acc != 8 || data_in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL full_capacity: accepted=%0d ready=%b required 8 and 0", acc, data_in_ready);
    end
  endtask

  task automatic test_simultaneous();
    drive(0, 1, 8'h18, 1);
    n_chk++;
    if (data_in_ready !== 1'b1 || data_out_valid !== 1'b1 || data_out !== 8'h10) begin
      n_fail++;
      $display("FAIL simul_pushpop: ready=%b valid=%b data=%h required 1 1 10", data_in_ready, data_out_valid, data_out);
    end
    advance();
    drive(0, 0, 8'h00, 0);
    n_chk++;
    if (data_in_ready !== 1'b0 || data_out_valid !== 1'b1 || data_out !== 8'h11) begin
      n_fail++;
      $display("FAIL simul_still_full: ready=%b valid=%b data=%h required 0 1 11", data_in_ready, data_out_valid, data_out);
    end
    advance();
    for (int e = 8'h11, c = 0; c < 40 && e <= 8'h18; c++) begin
      drive(0, 0, 8'h00, 1);
      n_chk++;
      if (obs !== exp_b) begin
        n_fail++;
        $display("FAIL drain_cycle c%0d: got %h required %h", c, obs, exp_b);
      end
      if (data_out_valid) begin
        n_chk++;
        if (data_out !== W'(e)) begin
          n_fail++;
          $display("FAIL drain_order: got %h required %h", data_out, W'(e));
        end
        e++;
      end
      advance();
    end
    drive(0, 0, 8'h00, 1);
    n_chk++;
    if (data_out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL drain_empty: valid=%b required 0", data_out_valid);
    end
    advance();
  endtask

  task automatic test_random();
    bit v = 0;
    bit o;
    logic [W-1:0] d = '0;
    bit stall = 0;
    logic [W-1:0] held = '0;
    for (int c = 0; c < 2000; c++) begin
      if (!v || data_in_ready) begin
        v = $urandom_range(0, 1) == 1;
        d = W'($urandom);
      end
      o = $urandom_range(0, 1) == 1;
      drive(0, v, d, o);
      n_chk++;
      if (obs !== exp_b) begin
        n_fail++;
        $display("FAIL random c%0d: got %h required %h", c, obs, exp_b);
      end
      if (stall) begin
        n_chk++;
        if (data_out_valid !== 1'b1 || data_out !== held) begin
          n_fail++;
          $display("FAIL random_stable c%0d: valid=%b data=%h required 1 %h", c, data_out_valid, data_out, held);
        end
      end
      stall = data_out_valid && !o;
      held = data_out;
      advance();
      if (v && exp_ready) v = 0;
    end
    for (int c = 0; c < 20; c++) begin
      drive(0, 0, 8'h00, 1);
      n_chk++;
      if (obs !== exp_b) begin
        n_fail++;
        $display("FAIL random_drain c%0d: got %h required %h", c, obs, exp_b);
      end
      advance();
    end
  endtask

  task automatic test_mid_reset();
    int got = 0;
    for (int i = 0; i < 5; i++) begin
      drive(0, 1, W'(8'hC0 + i), 0);
      advance();
    end
    drive(1, 0, 8'h00, 0);
    advance();
    drive(0, 0, 8'h00, 1);
    n_chk++;
    if (data_out_valid !== 1'b0 || data_in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL midreset_clear: valid=%b ready=%b required 0 1", data_out_valid, data_in_ready);
    end
    advance();
    for (int c = 0; c < 30; c++) begin
      drive(0, c < 4, W'(8'h50 + c), 1);
      n_chk++;
      if (obs !== exp_b) begin
        n_fail++;
        $display("FAIL midreset_cycle c%0d: got %h required %h", c, obs, exp_b);
      end
      if (data_out_valid) begin
        n_chk++;
        if (data_out !== W'(8'h50 + got)) begin
          n_fail++;
          $display("FAIL midreset_order: got %h required %h", data_out, W'(8'h50 + got));
        end
        got++;
      end
      advance();
    end
    n_chk++;
    if (got != 4) begin
      n_fail++;
      $display("FAIL midreset_count: got %0d beats required 4", got);
    end
  endtask

  initial begin
    test_reset();
    test_latency();
    test_full();
    test_simultaneous();
    test_random();
    test_mid_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
